// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: round-robin share of the register-file write port
// with per-requester holding buffers. Optional lookup: RF_WB_BYPASS_EN.
module rf_write_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
`ifdef RF_WB_BYPASS_EN
  input  logic [AW-1:0]        byp_addr,
  output logic                 byp_hit,
  output logic [DW-1:0]        byp_data,
`endif
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic                 we3,
  output logic [AW-1:0]        wa3,
  output logic [DW-1:0]        wd3,
  output logic [2**AW-1:0]     pending,
  output logic                 idle
);

  localparam int RW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int NR = 2**AW;

  logic [NREQ-1:0] r_full;
  logic [AW-1:0]   r_addr [NREQ];
  logic [DW-1:0]   r_data [NREQ];
  logic [RW-1:0]   r_rr;
  logic            r_we;
  logic [AW-1:0]   r_wa;
  logic [DW-1:0]   r_wd;
  logic [NR-1:0]   r_pend;

  logic            w_gv;
  logic [RW-1:0]   w_g;
  logic [NREQ-1:0] w_gnt;
  logic [NREQ-1:0] w_rnt;
  logic [NREQ-1:0] w_tie;
  logic [NREQ-1:0] w_acc;
  logic [AW-1:0]   w_ra [NREQ];
  logic [NR-1:0]   w_set;
  logic [NR-1:0]   w_clr;

  // Round-robin scan of full buffers starting at r_rr.
  always_comb begin
    int idx;
    idx   = 0;
    w_gv  = 1'b0;
    w_g   = '0;
    w_gnt = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(r_rr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!w_gv && r_full[idx]) begin
        w_gv = 1'b1;
        w_g  = RW'(idx);
      end
    end
    for (int i = 0; i < NREQ; i++)
      w_gnt[i] = w_gv && (w_g == RW'(i));
  end

  // Acceptance: free slot, no pending hazard, lower index wins ties.
  always_comb begin
    w_rnt = '0;
    w_tie = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_ra[i]  = req_addr[i*AW +: AW];
      w_rnt[i] = (~r_full[i] | w_gnt[i]) &
                 ~((w_ra[i] != '0) & r_pend[w_ra[i]]);
    end
    for (int i = 0; i < NREQ; i++)
      for (int j = 0; j < i; j++)
        if (req_valid[j] && w_rnt[j] &&
            (w_ra[j] == w_ra[i]) && (w_ra[i] != '0))
          w_tie[i] = 1'b1;
    req_ready = w_rnt & ~w_tie;
    w_acc     = req_valid & req_ready;
  end

  // Scoreboard set/clear masks for this edge.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (w_gv) w_clr[r_addr[w_g]] = 1'b1;
    for (int i = 0; i < NREQ; i++)
      if (w_acc[i] && (w_ra[i] != '0))
        w_set[w_ra[i]] = 1'b1;
  end

  // Buffers, output stage, pointer and scoreboard state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_full <= '0;
      r_rr   <= '0;
      r_we   <= 1'b0;
      r_wa   <= '0;
      r_wd   <= '0;
      r_pend <= '0;
      for (int i = 0; i < NREQ; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      r_we   <= w_gv;
      r_pend <= (r_pend & ~w_clr) | w_set;
      if (w_gv) begin
        r_wa <= r_addr[w_g];
        r_wd <= r_data[w_g];
        r_rr <= (w_g == RW'(NREQ-1)) ? '0 : w_g + RW'(1);
      end
      for (int i = 0; i < NREQ; i++) begin
        if (w_acc[i] && (w_ra[i] != '0)) begin
          r_full[i] <= 1'b1;
          r_addr[i] <= w_ra[i];
          r_data[i] <= req_data[i*DW +: DW];
        end else if (w_gnt[i]) begin
          r_full[i] <= 1'b0;
        end
      end
    end
  end

`ifdef RF_WB_BYPASS_EN
  // Forwarding lookup; a buffered entry is newer than the output stage.
  always_comb begin
    byp_hit  = 1'b0;
    byp_data = '0;
    if (byp_addr != '0) begin
      if (r_we && (r_wa == byp_addr)) begin
        byp_hit  = 1'b1;
        byp_data = r_wd;
      end
      for (int i = 0; i < NREQ; i++)
        if (r_full[i] && (r_addr[i] == byp_addr)) begin
          byp_hit  = 1'b1;
          byp_data = r_data[i];
        end
    end
  end
`endif

  assign we3     = r_we;
  assign wa3     = r_wa;
  assign wd3     = r_wd;
  assign pending = r_pend;
  assign idle    = ~|r_full & ~r_we;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed scenarios plus randomized traffic
// checked against a per-register outstanding-write model.
module tb_rf_write_arbiter;
  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NR   = 2**AW;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ*DW-1:0] req_data = '0;
  logic               we3;
  logic [AW-1:0]      wa3;
  logic [DW-1:0]      wd3;
  logic [NR-1:0]      pending;
  logic               idle;
`ifdef RF_WB_BYPASS_EN
  logic [AW-1:0]      byp_addr = '0;
  logic               byp_hit;
  logic [DW-1:0]      byp_data;
`endif

  int checks = 0;
  int passes = 0;

  rf_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk(clk),
    .reset(reset),
`ifdef RF_WB_BYPASS_EN
    .byp_addr(byp_addr),
    .byp_hit(byp_hit),
    .byp_data(byp_data),
`endif
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr(req_addr),
    .req_data(req_data),
    .we3(we3),
    .wa3(wa3),
    .wd3(wd3),
    .pending(pending),
    .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v,
                         input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req_valid[i]         = v;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic clr_req;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    clr_req();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    clr_req();
    tick();
    tick();
    checks++; if (we3 !== 1'b0) $display("FAIL rst_we3 got %0b want 0", we3); else passes++;
    checks++; if (wa3 !== '0) $display("FAIL rst_wa3 got %0d want 0", wa3); else passes++;
    checks++; if (wd3 !== '0) $display("FAIL rst_wd3 got %h want 0", wd3); else passes++;
    checks++; if (pending !== '0) $display("FAIL rst_pending got %h want 0", pending); else passes++;
    checks++; if (idle !== 1'b1) $display("FAIL rst_idle got %0b want 1", idle); else passes++;
    checks++; if (req_ready !== 3'b111) $display("FAIL rst_ready got %b want 111", req_ready); else passes++;
    reset = 1'b0;
  endtask

  task automatic test_single;
    logic [NR-1:0] e;
    e = '0;
    e[5] = 1'b1;
    do_reset();
    set_req(0, 1'b1, 5'd5, 32'h12345678);
    #1;
    checks++; if (req_ready[0] !== 1'b1) $display("FAIL single_ready got %0b want 1", req_ready[0]); else passes++;
    tick();
    clr_req();
    checks++; if (pending !== e) $display("FAIL single_pend1 got %h want %h", pending, e); else passes++;
    checks++; if (we3 !== 1'b0) $display("FAIL single_we_early got %0b want 0", we3); else passes++;
    checks++; if (idle !== 1'b0) $display("FAIL single_idle1 got %0b want 0", idle); else passes++;
    tick();
    checks++; if (we3 !== 1'b1) $display("FAIL single_we got %0b want 1", we3); else passes++;
    checks++; if (wa3 !== 5'd5) $display("FAIL single_wa got %0d want 5", wa3); else passes++;
    checks++; if (wd3 !== 32'h12345678) $display("FAIL single_wd got %h want 12345678", wd3); else passes++;
    checks++; if (pending !== '0) $display("FAIL single_pend2 got %h want 0", pending); else passes++;
    tick();
    checks++; if (we3 !== 1'b0) $display("FAIL single_we_off got %0b want 0", we3); else passes++;
    checks++; if (wa3 !== 5'd5) $display("FAIL single_wa_hold got %0d want 5", wa3); else passes++;
    checks++; if (idle !== 1'b1) $display("FAIL single_idle2 got %0b want 1", idle); else passes++;
  endtask

  task automatic test_three;
    logic [DW-1:0] ed;
    do_reset();
    set_req(0, 1'b1, 5'd1, 32'hA);
    set_req(1, 1'b1, 5'd2, 32'hB);
    set_req(2, 1'b1, 5'd3, 32'hC);
    #1;
    checks++; if (req_ready !== 3'b111) $display("FAIL three_ready got %b want 111", req_ready); else passes++;
    tick();
    clr_req();
    for (int k = 0; k < 3; k++) begin
      tick();
      ed = DW'(10 + k);
      checks++; if (we3 !== 1'b1 || wa3 !== AW'(k + 1) || wd3 !== ed)
        $display("FAIL three_seq%0d got we=%0b wa=%0d wd=%h want 1 %0d %h", k, we3, wa3, wd3, k + 1, ed);
      else passes++;
    end
    tick();
    checks++; if (we3 !== 1'b0 || idle !== 1'b1) $display("FAIL three_end got we=%0b idle=%0b want 0 1", we3, idle); else passes++;
    set_req(2, 1'b1, 5'd4, 32'h24);
    set_req(0, 1'b1, 5'd6, 32'h26);
    tick();
    clr_req();
    tick();
    checks++; if (we3 !== 1'b1 || wa3 !== 5'd6) $display("FAIL three_rr0 got we=%0b wa=%0d want 1 6", we3, wa3); else passes++;
    tick();
    checks++; if (we3 !== 1'b1 || wa3 !== 5'd4) $display("FAIL three_rr1 got we=%0b wa=%0d want 1 4", we3, wa3); else passes++;
    tick();
  endtask

  task automatic test_tie;
    do_reset();
    set_req(0, 1'b1, 5'd7, 32'h1);
    set_req(2, 1'b1, 5'd7, 32'h2);
    #1;
    checks++; if (req_ready[0] !== 1'b1) $display("FAIL tie_r0 got %0b want 1", req_ready[0]); else passes++;
    checks++; if (req_ready[2] !== 1'b0) $display("FAIL tie_r2 got %0b want 0", req_ready[2]); else passes++;
    tick();
    set_req(0, 1'b0, 5'd0, 32'h0);
    #1;
    checks++; if (req_ready[2] !== 1'b0) $display("FAIL tie_block got %0b want 0", req_ready[2]); else passes++;
    checks++; if (pending[7] !== 1'b1) $display("FAIL tie_pend got %0b want 1", pending[7]); else passes++;
    tick();
    checks++; if (we3 !== 1'b1 || wa3 !== 5'd7 || wd3 !== 32'h1)
      $display("FAIL tie_w1 got we=%0b wa=%0d wd=%h want 1 7 1", we3, wa3, wd3);
    else passes++;
    checks++; if (req_ready[2] !== 1'b1) $display("FAIL tie_r2_go got %0b want 1", req_ready[2]); else passes++;
    tick();
    clr_req();
    checks++; if (we3 !== 1'b0 || pending[7] !== 1'b1)
      $display("FAIL tie_acc got we=%0b pend=%0b want 0 1", we3, pending[7]);
    else passes++;
    tick();
    checks++; if (we3 !== 1'b1 || wa3 !== 5'd7 || wd3 !== 32'h2)
      $display("FAIL tie_w2 got we=%0b wa=%0d wd=%h want 1 7 2", we3, wa3, wd3);
    else passes++;
    tick();
  endtask

  task automatic test_r0;
    do_reset();
    set_req(1, 1'b1, 5'd0, 32'hFFFFFFFF);
    #1;
    checks++; if (req_ready[1] !== 1'b1) $display("FAIL r0_ready got %0b want 1", req_ready[1]); else passes++;
    tick();
    clr_req();
    checks++; if (pending !== '0 || idle !== 1'b1)
      $display("FAIL r0_state got pend=%h idle=%0b want 0 1", pending, idle);
    else passes++;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (we3 !== 1'b0) $display("FAIL r0_we%0d got %0b want 0", k, we3); else passes++;
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    set_req(0, 1'b1, 5'd10, 32'hAA);
    set_req(1, 1'b1, 5'd11, 32'hBB);
    tick();
    clr_req();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (we3 !== 1'b0 || pending !== '0 || idle !== 1'b1)
      $display("FAIL rmid_state got we=%0b pend=%h idle=%0b want 0 0 1", we3, pending, idle);
    else passes++;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (we3 !== 1'b0) $display("FAIL rmid_we%0d got %0b want 0", k, we3); else passes++;
    end
  endtask

`ifdef RF_WB_BYPASS_EN
  task automatic test_bypass;
    do_reset();
    byp_addr = 5'd9;
    set_req(0, 1'b1, 5'd9, 32'h44);
    tick();
    clr_req();
    #1;
    checks++; if (byp_hit !== 1'b1 || byp_data !== 32'h44)
      $display("FAIL byp_buf1 got %0b %h want 1 44", byp_hit, byp_data);
    else passes++;
    tick();
    checks++; if (byp_hit !== 1'b1 || byp_data !== 32'h44)
      $display("FAIL byp_out got %0b %h want 1 44", byp_hit, byp_data);
    else passes++;
    set_req(1, 1'b1, 5'd9, 32'h55);
    tick();
    clr_req();
    checks++; if (byp_hit !== 1'b1 || byp_data !== 32'h55)
      $display("FAIL byp_buf2 got %0b %h want 1 55", byp_hit, byp_data);
    else passes++;
    byp_addr = 5'd0;
    #1;
    checks++; if (byp_hit !== 1'b0 || byp_data !== '0)
      $display("FAIL byp_zero got %0b %h want 0 0", byp_hit, byp_data);
    else passes++;
    byp_addr = 5'd12;
    #1;
    checks++; if (byp_hit !== 1'b0 || byp_data !== '0)
      $display("FAIL byp_miss got %0b %h want 0 0", byp_hit, byp_data);
    else passes++;
    byp_addr = 5'd0;
    tick();
    tick();
  endtask
`endif

  task automatic test_random;
    logic          m_v   [NR];
    logic [DW-1:0] m_d   [NR];
    int            m_r   [NR];
    int            m_age [NR];
    logic          m_own [NREQ];
    logic [NREQ-1:0] acc;
    logic [AW-1:0] a;
    logic [AW-1:0] aj;
    logic [NR-1:0] ep;
    logic          lower;
    logic          any;
    int            maxage;
    do_reset();
    for (int r = 0; r < NR; r++) begin
      m_v[r] = 1'b0; m_d[r] = '0; m_r[r] = 0; m_age[r] = 0;
    end
    for (int i = 0; i < NREQ; i++) m_own[i] = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < NREQ; i++)
        set_req(i, (cyc < 590) && ($urandom_range(0, 99) < 60),
                AW'($urandom_range(0, 7)), DW'($urandom));
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i]) continue;
        a = req_addr[i*AW +: AW];
        if (a != '0 && m_v[a]) begin
          checks++; if (req_ready[i] !== 1'b0) $display("FAIL rnd_conflict c%0d req%0d r%0d got 1 want 0", cyc, i, a); else passes++;
        end
        lower = 1'b0;
        for (int j = 0; j < i; j++) begin
          aj = req_addr[j*AW +: AW];
          if (req_valid[j] && aj == a && a != '0) lower = 1'b1;
        end
        if (!m_own[i] && (a == '0 || !m_v[a]) && !lower) begin
          checks++; if (req_ready[i] !== 1'b1) $display("FAIL rnd_stall c%0d req%0d r%0d got 0 want 1", cyc, i, a); else passes++;
        end
      end
      acc = req_valid & req_ready;
      tick();
      if (we3 === 1'b1) begin
        checks++;
        if (wa3 == '0 || !m_v[wa3] || m_d[wa3] !== wd3)
          $display("FAIL rnd_write c%0d got r%0d=%h want r%0d=%h v=%0b", cyc, wa3, wd3, wa3, m_d[wa3], m_v[wa3]);
        else passes++;
        if (wa3 != '0 && m_v[wa3]) begin
          m_v[wa3] = 1'b0;
          m_own[m_r[wa3]] = 1'b0;
        end
      end
      maxage = 0;
      for (int r = 0; r < NR; r++)
        if (m_v[r]) begin
          m_age[r]++;
          if (m_age[r] > maxage) maxage = m_age[r];
        end
      checks++; if (maxage >= NREQ) $display("FAIL rnd_fair c%0d got age %0d want <%0d", cyc, maxage, NREQ); else passes++;
      for (int i = 0; i < NREQ; i++) begin
        if (!acc[i]) continue;
        a = req_addr[i*AW +: AW];
        checks++;
        if (m_own[i] || (a != '0 && m_v[a]))
          $display("FAIL rnd_accept c%0d req%0d r%0d got accepted want stall", cyc, i, a);
        else passes++;
        if (a != '0) begin
          m_v[a] = 1'b1; m_d[a] = req_data[i*DW +: DW];
          m_r[a] = i; m_age[a] = 0; m_own[i] = 1'b1;
        end
      end
      ep = '0;
      any = 1'b0;
      for (int r = 0; r < NR; r++) begin
        ep[r] = m_v[r];
        if (m_v[r]) any = 1'b1;
      end
      checks++; if (pending !== ep) $display("FAIL rnd_pending c%0d got %h want %h", cyc, pending, ep); else passes++;
      checks++; if (idle !== (!any && we3 !== 1'b1)) $display("FAIL rnd_idle c%0d got %0b want %0b", cyc, idle, !any && we3 !== 1'b1); else passes++;
    end
    any = 1'b0;
    for (int r = 0; r < NR; r++) if (m_v[r]) any = 1'b1;
    checks++; if (any || idle !== 1'b1) $display("FAIL rnd_drain got left=%0b idle=%0b want 0 1", any, idle); else passes++;
    clr_req();
  endtask

  initial begin
    test_reset();
    test_single();
    test_three();
    test_tie();
    test_r0();
    test_reset_mid();
`ifdef RF_WB_BYPASS_EN
    test_bypass();
`endif
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the single register-file write port (we3/wa3/wd3) between NREQ writeback requesters, e.g. ALU, load unit and debug.
- Each requester has a one-entry holding buffer with a valid/ready handshake.
- Full buffers are drained round-robin through a registered output stage that drives the register file write port.
- A pending-address scoreboard keeps write order correct per register and exposes hazards to the control unit.

Parameters:
- NREQ, 3, number of requesters (2..8).
- AW, 5, register address width.
- DW, 32, data width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  requester i presents a write.
- req_ready  output  NREQ  requester i's write is accepted this cycle when valid&ready.
- req_addr  input  NREQ*AW  destination register for requester i, packed at bits [i*AW +: AW].
- req_data  input  NREQ*DW  write data for requester i, packed at bits [i*DW +: DW].
- we3  output  1  register file write enable (registered).
- wa3  output  AW  register file write address (registered).
- wd3  output  DW  register file write data (registered).
- pending  output  2**AW  bit r set when any holding buffer holds a write to register r.
- idle  output  1  no buffer full and we3==0.

Behaviour:
- Reset values (reset high at an edge): all buffers empty, pending=0, we3=0, wa3=0, wd3=0, round-robin pointer rr=0, idle=1.
- Reset mid-operation discards all buffered and in-flight writes; nothing is written after the reset edge.
- Arbitration (combinational, each cycle): among full buffers, grant the first index found scanning rr, rr+1, ... mod NREQ. At most one grant per cycle.
- On the edge with a grant g:
  - we3<=1, wa3<=buf_addr[g], wd3<=buf_data[g].
  - Buffer g empties; rr<=(g+1) mod NREQ.
- On an edge with no grant: we3<=0; wa3 and wd3 hold their values; rr holds.
- Acceptance: req_ready[i] = (~full[i] | grant==i) & ~conflict[i] & ~tie[i].
  - conflict[i]: req_addr[i]!=0 and pending[req_addr[i]]==1. Uses the registered pending, so an entry being granted this cycle still blocks for one cycle.
  - tie[i]: some j<i has req_valid[j], req_ready-without-tie[j] and req_addr[j]==req_addr[i]!=0. The lower index wins; the higher index stalls.
- These rules ensure at most one buffered write per register at any time, so per-register write order equals acceptance order.
- Address 0: accept when ~full[i] | grant==i. The write is discarded: the buffer is not filled, pending is unchanged, and no we3 pulse occurs.
- pending[r] is updated at the edge: set on acceptance into a buffer, cleared when that buffer is granted. Set and clear of different registers in the same edge are both applied. pending[0] is always 0.
- Latency: accepted at edge k → earliest grant in cycle k+1 → we3/wa3/wd3 valid after edge k+1 → register written at edge k+2.
- Throughput: one register-file write per cycle total. A single requester sustains one write per cycle only while its addresses do not repeat back-to-back; a back-to-back repeat stalls one cycle.
- Fairness: any full buffer is granted within NREQ cycles.
- req_ready may depend combinationally on req_valid and req_addr. There is no combinational path from req_* to we3/wa3/wd3.

Optional Feature:
- Macro RF_WB_BYPASS_EN.
- When defined, add ports:
  - byp_addr  input  AW
  - byp_hit  output  1
  - byp_data  output  DW
- The lookup is combinational:
  - A hit in a full buffer with matching address returns that buffer's data.
  - Otherwise, if we3==1 and wa3==byp_addr, return wd3.
  - byp_addr==0 always gives byp_hit=0, byp_data=0.
  - A miss gives byp_hit=0, byp_data=0.
- A buffer hit has priority over the output stage because the buffer entry is newer.
- When undefined, these ports and the lookup logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then requester 0 writes r5=0x12345678 → we3=1, wa3=5, wd3=0x12345678 after the second edge; pending[5] is set for exactly one cycle; idle returns to 1.
- All three requesters valid in the same cycle with r1=0xA, r2=0xB, r3=0xC → three accepted; we3 pulses on three consecutive cycles in order r1, r2, r3; rr returns to 0.
- Requesters 0 and 2 both write r7 (0x1, then 0x2) in the same cycle → req_ready[2]=0; requester 2 is accepted after pending[7] clears; final write sequence is r7=0x1 then r7=0x2.
- Write to r0 with data 0xFFFFFFFF → req_ready=1, pending stays 0, and no we3 pulse occurs.
- Reset asserted while two buffers are full → the following cycle has we3=0, pending=0, idle=1, and no write occurs.
- With RF_WB_BYPASS_EN: buffer holds r9=0x55 while the output stage has wa3=9, wd3=0x44 → byp_addr=9 gives byp_hit=1, byp_data=0x55; byp_addr=0 gives byp_hit=0.
